// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface mips_mc_controller_if #(
    parameter int ALU_W = 3
);
    logic [3:0]       opcode;
    logic [8:0]       func;
    logic             MemRead;
    logic             MemWrite;
    logic             IOrD;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCWriteCond;
    logic [1:0]       PCSrc;
    logic             AluSrcA;
    logic [1:0]       AluSrcB;
    logic             ImSel;
    logic [ALU_W-1:0] AluOperation;
    logic             RegWrite;
    logic             RegDst;
    logic             MemToReg;
    logic             illegal_op;
    logic [3:0]       state_dbg;

    modport master (
        input  opcode, func,
        output MemRead, MemWrite, IOrD, IRWrite, PCWrite, PCWriteCond, PCSrc,
               AluSrcA, AluSrcB, ImSel, AluOperation, RegWrite, RegDst,
               MemToReg, illegal_op, state_dbg
    );

    modport slave (
        output opcode, func,
        input  MemRead, MemWrite, IOrD, IRWrite, PCWrite, PCWriteCond, PCSrc,
               AluSrcA, AluSrcB, ImSel, AluOperation, RegWrite, RegDst,
               MemToReg, illegal_op, state_dbg
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Multi-cycle control FSM for the 16-bit accumulator MIPS datapath.
// Outputs are a Moore decode of the state register, except the C_EX ALU op and the DECODE illegal_op flag.
module mips_mc_controller #(
    parameter int ALU_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_mc_controller_if.master  bus
);
    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEM_RD = 4'd3,
        LD_WB  = 4'd4,
        MEM_WR = 4'd5,
        JMP    = 4'd6,
        BRZ    = 4'd7,
        C_EX   = 4'd8,
        C_WB   = 4'd9,
        I_EX   = 4'd10,
        I_WB   = 4'd11
    } state_t;

    localparam logic [ALU_W-1:0] ALU_PASSB = 3'b000;
    localparam logic [ALU_W-1:0] ALU_NOTA  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_PASSA = 3'b010;
    localparam logic [ALU_W-1:0] ALU_ADD   = 3'b100;
    localparam logic [ALU_W-1:0] ALU_SUB   = 3'b101;
    localparam logic [ALU_W-1:0] ALU_AND   = 3'b110;
    localparam logic [ALU_W-1:0] ALU_OR    = 3'b111;

    state_t state_r;
    state_t next_state_s;
    logic   c_legal_s;

    // A C-type function is valid only when exactly one of bits 0..7 is set.
    function automatic logic func_legal(input logic [8:0] f);
        return (f[8] == 1'b0) && $onehot(f[7:0]);
    endfunction

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= INIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state_s     = state_r;
        c_legal_s        = func_legal(bus.func);
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IOrD         = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.PCSrc        = 2'd0;
        bus.AluSrcA      = 1'b0;
        bus.AluSrcB      = 2'd0;
        bus.ImSel        = 1'b0;
        bus.AluOperation = ALU_PASSB;
        bus.RegWrite     = 1'b0;
        bus.RegDst       = 1'b0;
        bus.MemToReg     = 1'b0;
        bus.illegal_op   = 1'b0;
        bus.state_dbg    = state_r;
        case (state_r)
            INIT: begin
                next_state_s = FETCH;
            end
            FETCH: begin
                bus.MemRead      = 1'b1;
                bus.IRWrite      = 1'b1;
                bus.AluSrcB      = 2'd2;
                bus.AluOperation = ALU_ADD;
                bus.PCWrite      = 1'b1;
                next_state_s     = DECODE;
            end
            DECODE: begin
                casez (bus.opcode)
                    4'b0000: next_state_s = MEM_RD;
                    4'b0001: next_state_s = MEM_WR;
                    4'b0010: next_state_s = JMP;
                    4'b0100: next_state_s = BRZ;
                    4'b1000: begin
                        if (!c_legal_s) begin
                            bus.illegal_op = 1'b1;
                            next_state_s   = FETCH;
                        end else if (bus.func[7]) begin
                            next_state_s = FETCH;
                        end else begin
                            next_state_s = C_EX;
                        end
                    end
                    4'b11??: next_state_s = I_EX;
                    default: begin
                        bus.illegal_op = 1'b1;
                        next_state_s   = FETCH;
                    end
                endcase
            end
            MEM_RD: begin
                bus.IOrD     = 1'b1;
                bus.MemRead  = 1'b1;
                next_state_s = LD_WB;
            end
            LD_WB: begin
                bus.MemToReg = 1'b1;
                bus.RegWrite = 1'b1;
                next_state_s = FETCH;
            end
            MEM_WR: begin
                bus.IOrD     = 1'b1;
                bus.MemWrite = 1'b1;
                next_state_s = FETCH;
            end
            JMP: begin
                bus.PCSrc    = 2'd1;
                bus.PCWrite  = 1'b1;
                next_state_s = FETCH;
            end
            BRZ: begin
                bus.AluSrcA      = 1'b1;
                bus.AluOperation = ALU_PASSA;
                bus.PCSrc        = 2'd2;
                bus.PCWriteCond  = 1'b1;
                next_state_s     = FETCH;
            end
            C_EX: begin
                bus.AluSrcA = 1'b1;
                case (bus.func)
                    9'h001:  bus.AluOperation = ALU_PASSA;
                    9'h002:  bus.AluOperation = ALU_PASSB;
                    9'h004:  bus.AluOperation = ALU_ADD;
                    9'h008:  bus.AluOperation = ALU_SUB;
                    9'h010:  bus.AluOperation = ALU_AND;
                    9'h020:  bus.AluOperation = ALU_OR;
                    9'h040:  bus.AluOperation = ALU_NOTA;
                    default: bus.AluOperation = ALU_PASSB;
                endcase
                next_state_s = C_WB;
            end
            C_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                next_state_s = FETCH;
            end
            I_EX: begin
                bus.AluSrcA  = 1'b1;
                bus.AluSrcB  = 2'd1;
                bus.ImSel    = 1'b1;
                next_state_s = I_WB;
            end
            I_WB: begin
                bus.RegWrite = 1'b1;
                next_state_s = FETCH;
            end
            default: begin
                next_state_s = INIT;
            end
        endcase
    end
endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench: an instruction-level model queues expected per-cycle control vectors; a monitor compares each cycle.
module tb_mips_mc_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_mc_controller_if #(.ALU_W(3)) bus ();
    mips_mc_controller #(.ALU_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic       mr, mw, iord, irw, pcw, pcwc;
        logic [1:0] pcsrc;
        logic       asa;
        logic [1:0] asb;
        logic       ims;
        logic [2:0] aop;
        logic       rw, rd, m2r, ill;
        logic [3:0] sd;
    } vec_t;

    typedef struct packed {
        logic chk_sd;
        vec_t v;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [2:0] c_alu(input logic [8:0] fn);
        logic [2:0] tbl [7] = '{3'b010, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
        for (int k = 0; k < 7; k++) begin
            if (fn == (9'd1 << k)) return tbl[k];
        end
        return 3'b000;
    endfunction

    task automatic push(input vec_t v, input logic chk);
        exp_t e;
        e.chk_sd = chk;
        e.v      = v;
        q.push_back(e);
    endtask

    task automatic idle_cycle(input logic rst_val);
        @(posedge clk);
        #1;
        rst = rst_val;
        push('0, 1'b1);
    endtask

    // Issue one instruction; if rst_at >= 0, reset is pulled low during that cycle of it.
    task automatic issue(input logic [3:0] op, input logic [8:0] fn, input int rst_at);
        vec_t s[$];
        vec_t v;
        logic c_ok;
        c_ok = (op == 4'd8) && (fn[8] == 1'b0) && ($countones(fn) == 1);
        v = '0; v.mr = 1'b1; v.irw = 1'b1; v.pcw = 1'b1; v.asb = 2'd2; v.aop = 3'b100;
        s.push_back(v);
        v = '0;
        v.ill = !(op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd4 || op >= 4'd12 || c_ok);
        s.push_back(v);
        if (op == 4'd0) begin
            v = '0; v.iord = 1'b1; v.mr = 1'b1; s.push_back(v);
            v = '0; v.m2r = 1'b1; v.rw = 1'b1; s.push_back(v);
        end else if (op == 4'd1) begin
            v = '0; v.iord = 1'b1; v.mw = 1'b1; s.push_back(v);
        end else if (op == 4'd2) begin
            v = '0; v.pcsrc = 2'd1; v.pcw = 1'b1; s.push_back(v);
        end else if (op == 4'd4) begin
            v = '0; v.asa = 1'b1; v.aop = 3'b010; v.pcsrc = 2'd2; v.pcwc = 1'b1; s.push_back(v);
        end else if (c_ok && fn != 9'h080) begin
            v = '0; v.asa = 1'b1; v.aop = c_alu(fn); s.push_back(v);
            v = '0; v.rw = 1'b1; v.rd = 1'b1; s.push_back(v);
        end else if (op >= 4'd12) begin
            v = '0; v.asa = 1'b1; v.asb = 2'd1; v.ims = 1'b1; s.push_back(v);
            v = '0; v.rw = 1'b1; s.push_back(v);
        end
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                bus.opcode = op;
                bus.func   = fn;
            end
            if (i == rst_at) begin
                rst = 1'b0;
                push('0, 1'b1);
                idle_cycle(1'b0);
                idle_cycle(1'b1);
                return;
            end
            push(s[i], 1'b0);
        end
    endtask

    // Monitor: one expected vector per cycle, checked mid-cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        vec_t a;
        vec_t m;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {bus.MemRead, bus.MemWrite, bus.IOrD, bus.IRWrite, bus.PCWrite, bus.PCWriteCond,
                 bus.PCSrc, bus.AluSrcA, bus.AluSrcB, bus.ImSel, bus.AluOperation,
                 bus.RegWrite, bus.RegDst, bus.MemToReg, bus.illegal_op, bus.state_dbg};
            m = e.chk_sd ? '1 : {19'h7FFFF, 4'h0};
            n_vec++;
            if ((a & m) !== (e.v & m)) begin
                n_bad++;
                $display("FAIL ctrl_vec t=%0t opcode=%h func=%h got=%h expected=%h mask=%h",
                         $time, bus.opcode, bus.func, a, e.v, m);
            end
        end
    end

    initial begin
        logic [3:0] op;
        logic [8:0] fn;
        bus.opcode = 4'd0;
        bus.func   = 9'd0;
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        issue(4'd0,  9'h000, -1);
        issue(4'd1,  9'h000, -1);
        issue(4'd8,  9'h004, -1);
        issue(4'd8,  9'h001, -1);
        issue(4'd8,  9'h080, -1);
        issue(4'd8,  9'h006, -1);
        issue(4'd4,  9'h000, -1);
        issue(4'd2,  9'h000, -1);
        issue(4'd3,  9'h000, -1);
        issue(4'd13, 9'h000, -1);
        issue(4'd13, 9'h000, 2);
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) fn = 9'($urandom_range(0, 511));
            else fn = 9'd1 << $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 0) op = 4'd8;
            issue(op, fn, ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 3)) : -1);
        end
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain left=%0d expected=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
